// File: rtl/tick_bcd_counter.sv
`default_nettype none
// ============================================================================
// Module   : tick_bcd_counter
// Purpose  : Packed-BCD up/down modulo counter. It steps on synchronised
//            rising edges of an asynchronous slow_clk and has a validated load.
// Revision : 1.0 - initial release
// ============================================================================
module tick_bcd_counter #(
  parameter int MOD         = 60,
  parameter int SYNC_STAGES = 2
) (
  input  logic       I_CLK,
  input  logic       rst,
  input  logic       slow_clk,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] bcd,
  output logic       tick,
  output logic       tc,
  output logic       load_err
);

  localparam logic [3:0] c_MAX_TENS = 4'((MOD - 1) / 10);
  localparam logic [3:0] c_MAX_ONES = 4'((MOD - 1) % 10);
  localparam logic [7:0] c_MOD      = 8'(MOD);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic [3:0]             r_tens;
  logic [3:0]             r_ones;
  logic                   r_tc;
  logic                   r_load_err;

  logic [7:0] w_load_bin;
  logic       w_load_ok;
  logic       w_at_max;
  logic       w_at_zero;
  logic       w_step;
  logic [3:0] w_nxt_tens;
  logic [3:0] w_nxt_ones;
  logic       w_wrap;

  // Flops reset high to match the divider's reset level, so releasing reset
  // with slow_clk high cannot manufacture an edge.
  always_ff @(posedge I_CLK or posedge rst) begin
    if (rst) begin
      r_sync <= '1;
      r_hist <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], slow_clk};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign tick = r_sync[SYNC_STAGES-1] & ~r_hist;

  assign w_load_bin = ({4'd0, load_val[7:4]} * 8'd10) + {4'd0, load_val[3:0]};
  assign w_load_ok  = (load_val[7:4] <= 4'd9) && (load_val[3:0] <= 4'd9) &&
                      (w_load_bin < c_MOD);

  assign w_at_max  = (r_tens == c_MAX_TENS) && (r_ones == c_MAX_ONES);
  assign w_at_zero = (r_tens == 4'd0) && (r_ones == 4'd0);
  assign w_step    = tick && en && !load;

  always_comb begin
    w_nxt_tens = r_tens;
    w_nxt_ones = r_ones;
    w_wrap     = 1'b0;
    if (up) begin
      if (w_at_max) begin
        w_nxt_tens = 4'd0;
        w_nxt_ones = 4'd0;
        w_wrap     = 1'b1;
      end else if (r_ones == 4'd9) begin
        w_nxt_ones = 4'd0;
        w_nxt_tens = r_tens + 4'd1;
      end else begin
        w_nxt_ones = r_ones + 4'd1;
      end
    end else begin
      if (w_at_zero) begin
        w_nxt_tens = c_MAX_TENS;
        w_nxt_ones = c_MAX_ONES;
        w_wrap     = 1'b1;
      end else if (r_ones == 4'd0) begin
        w_nxt_ones = 4'd9;
        w_nxt_tens = r_tens - 4'd1;
      end else begin
        w_nxt_ones = r_ones - 4'd1;
      end
    end
  end

  // Load wins over a coincident tick; that tick is simply consumed.
  always_ff @(posedge I_CLK or posedge rst) begin
    if (rst) begin
      r_tens     <= 4'd0;
      r_ones     <= 4'd0;
      r_tc       <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_tc       <= 1'b0;
      r_load_err <= 1'b0;
      if (load) begin
        if (w_load_ok) begin
          r_tens <= load_val[7:4];
          r_ones <= load_val[3:0];
        end else begin
          r_load_err <= 1'b1;
        end
      end else if (w_step) begin
        r_tens <= w_nxt_tens;
        r_ones <= w_nxt_ones;
        r_tc   <= w_wrap;
      end
    end
  end

  assign bcd      = {r_tens, r_ones};
  assign tc       = r_tc;
  assign load_err = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_tick_bcd_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tick_bcd_counter
// Purpose  : Directed self-checking bench for tick_bcd_counter (MOD=60, 2 sync).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tick_bcd_counter;

  logic       I_CLK = 1'b0;
  logic       rst;
  logic       slow_clk;
  logic       en;
  logic       up;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] bcd;
  logic       tick;
  logic       tc;
  logic       load_err;

  int checks   = 0;
  int failures = 0;
  int tc_total = 0;

  tick_bcd_counter #(.MOD(60), .SYNC_STAGES(2)) dut (
    .I_CLK    (I_CLK),
    .rst      (rst),
    .slow_clk (slow_clk),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .bcd      (bcd),
    .tick     (tick),
    .tc       (tc),
    .load_err (load_err)
  );

  always #5 I_CLK = ~I_CLK;

  always @(negedge I_CLK) if (tc === 1'b1) tc_total++;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered and left at a falling edge. Raises slow_clk for 3 cycles, lowers it for 3.
  task automatic slow_period(output logic t_early, output logic t_seen,
                             output logic [7:0] b_mid, output logic tc_seen);
    slow_clk = 1'b1;
    @(negedge I_CLK) t_early = tick;
    @(negedge I_CLK) begin t_seen = tick; b_mid = bcd; end
    @(negedge I_CLK) tc_seen = tc;
    slow_clk = 1'b0;
    repeat (3) @(negedge I_CLK);
  endtask

  task automatic do_load(input logic [7:0] val);
    load = 1'b1;
    load_val = val;
    @(negedge I_CLK);
    load = 1'b0;
  endtask

  initial begin
    logic       te, ts, tcs, any;
    logic [7:0] bm, e;
    int         tc_base;

    rst = 1'b1; slow_clk = 1'b1; en = 1'b1; up = 1'b1; load = 1'b0; load_val = 8'h00;
    #2;
    check("reset_bcd", bcd, 8'h00);
    check("reset_tc", {7'd0, tc}, 8'h00);
    check("reset_load_err", {7'd0, load_err}, 8'h00);
    check("reset_tick", {7'd0, tick}, 8'h00);
    @(negedge I_CLK); @(negedge I_CLK);
    rst = 1'b0;

    // Release with slow_clk high must not produce a tick.
    any = 1'b0;
    repeat (10) @(negedge I_CLK) any |= tick;
    check("release_high_no_tick", {7'd0, any}, 8'h00);
    check("release_high_bcd", bcd, 8'h00);
    slow_clk = 1'b0;
    repeat (3) @(negedge I_CLK);

    // Full cycle 00..59..00 with a single tc on the wrap.
    tc_base = tc_total;
    for (int i = 1; i <= 60; i++) begin
      slow_period(te, ts, bm, tcs);
      e[7:4] = 4'((i % 60) / 10);
      e[3:0] = 4'((i % 60) % 10);
      check($sformatf("count_%0d", i), bcd, e);
      if (i == 1 || i == 60) begin
        check($sformatf("tick_early_%0d", i), {7'd0, te}, 8'h00);
        check($sformatf("tick_seen_%0d", i), {7'd0, ts}, 8'h01);
        e[7:4] = 4'((i - 1) / 10);
        e[3:0] = 4'((i - 1) % 10);
        check($sformatf("bcd_before_step_%0d", i), bm, e);
      end
      check($sformatf("tc_%0d", i), {7'd0, tcs}, (i == 60) ? 8'h01 : 8'h00);
    end
    check("tc_pulse_count", 8'(tc_total - tc_base), 8'h01);

    // Down counting and down wrap.
    up = 1'b0;
    slow_period(te, ts, bm, tcs);
    check("down_wrap_bcd", bcd, 8'h59);
    check("down_wrap_tc", {7'd0, tcs}, 8'h01);
    slow_period(te, ts, bm, tcs);
    check("down_58_bcd", bcd, 8'h58);
    check("down_58_tc", {7'd0, tcs}, 8'h00);
    do_load(8'h10);
    check("load_10", bcd, 8'h10);
    check("load_10_err", {7'd0, load_err}, 8'h00);
    slow_period(te, ts, bm, tcs);
    check("down_10_to_09", bcd, 8'h09);

    // Load coincident with tick: load wins, tick consumed.
    up = 1'b1;
    slow_clk = 1'b1;
    @(negedge I_CLK); @(negedge I_CLK);
    check("tick_before_load", {7'd0, tick}, 8'h01);
    load = 1'b1; load_val = 8'h42;
    @(negedge I_CLK);
    load = 1'b0;
    check("load_over_tick", bcd, 8'h42);
    check("load_over_tick_tc", {7'd0, tc}, 8'h00);
    slow_clk = 1'b0;
    repeat (4) @(negedge I_CLK);
    check("no_late_step", bcd, 8'h42);

    // Rejected loads.
    do_load(8'h3A);
    check("bad_nibble_bcd", bcd, 8'h42);
    check("bad_nibble_err", {7'd0, load_err}, 8'h01);
    @(negedge I_CLK);
    check("err_one_cycle", {7'd0, load_err}, 8'h00);
    do_load(8'h60);
    check("too_big_bcd", bcd, 8'h42);
    check("too_big_err", {7'd0, load_err}, 8'h01);

    // Held load: repeated accepts, then repeated rejects.
    load = 1'b1; load_val = 8'h15;
    @(negedge I_CLK) check("hold_load_a", bcd, 8'h15);
    load_val = 8'h16;
    @(negedge I_CLK) check("hold_load_b", bcd, 8'h16);
    load_val = 8'h7F;
    @(negedge I_CLK) check("hold_bad_a", {7'd0, load_err}, 8'h01);
    @(negedge I_CLK) check("hold_bad_b", {7'd0, load_err}, 8'h01);
    check("hold_bad_bcd", bcd, 8'h16);
    load = 1'b0;

    // Boundary load 59 then up wrap.
    do_load(8'h59);
    check("load_59", bcd, 8'h59);
    slow_period(te, ts, bm, tcs);
    check("up_wrap_bcd", bcd, 8'h00);
    check("up_wrap_tc", {7'd0, tcs}, 8'h01);

    // Disabled ticks are dropped, not queued.
    do_load(8'h20);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      slow_period(te, ts, bm, tcs);
      check($sformatf("en0_tick_%0d", i), {7'd0, ts}, 8'h01);
      check($sformatf("en0_bcd_%0d", i), bcd, 8'h20);
    end
    en = 1'b1;
    repeat (3) @(negedge I_CLK);
    check("en1_no_queued", bcd, 8'h20);
    slow_period(te, ts, bm, tcs);
    check("en1_step", bcd, 8'h21);

    // Asynchronous reset mid-count with a rise in flight.
    do_load(8'h27);
    check("pre_reset_27", bcd, 8'h27);
    slow_clk = 1'b1;
    @(posedge I_CLK);
    #2 rst = 1'b1;
    #1;
    check("async_reset_bcd", bcd, 8'h00);
    check("async_reset_tick", {7'd0, tick}, 8'h00);
    @(negedge I_CLK);
    rst = 1'b0;
    any = 1'b0;
    tc_base = tc_total;
    repeat (6) @(negedge I_CLK) any |= tick;
    check("post_reset_no_tick", {7'd0, any}, 8'h00);
    check("post_reset_no_tc", 8'(tc_total - tc_base), 8'h00);
    check("post_reset_bcd", bcd, 8'h00);
    slow_clk = 1'b0;
    repeat (3) @(negedge I_CLK);
    slow_period(te, ts, bm, tcs);
    check("fresh_rise_step", bcd, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tick_bcd_counter.md
TICK_BCD_COUNTER -- requirements
Module: tick_bcd_counter

Interface
REQ-001 Parameter MOD, default 60: count modulus; legal range 2..100; count spans 0..MOD-1.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth for slow_clk; legal range 2..3.
REQ-003 I_CLK  input  1  system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 slow_clk  input  1  divided clock from the upstream divider; treated as asynchronous data, never used as a clock.
REQ-006 en  input  1  count enable, sampled on I_CLK.
REQ-007 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-008 load  input  1  synchronous load strobe.
REQ-009 load_val  input  8  packed BCD load value: [7:4] tens, [3:0] ones.
REQ-010 bcd  output  8  current count, packed BCD: [7:4] tens, [3:0] ones.
REQ-011 tick  output  1  one-I_CLK-cycle pulse per detected slow_clk rising edge.
REQ-012 tc  output  1  registered terminal-count pulse, one cycle wide, on wrap.
REQ-013 load_err  output  1  registered one-cycle pulse when a load is rejected.

Function
REQ-014 slow_clk passes through a SYNC_STAGES-deep flop chain, plus one history flop; tick = last sync stage AND NOT history flop (combinational from registers).
REQ-015 Latency: a slow_clk rise first sampled at I_CLK edge E drives tick high during the cycle after edge E+SYNC_STAGES-1; bcd changes at the next edge.
REQ-016 A count step occurs only at an edge where tick=1, en=1 and load=0; otherwise bcd holds.
REQ-017 Up step: ones 9 -> 0 with tens+1; otherwise ones+1. At count MOD-1 -> 0 and tc=1 for one cycle.
REQ-018 Down step: ones 0 -> 9 with tens-1; otherwise ones-1. At count 0 -> MOD-1 and tc=1 for one cycle.
REQ-019 tc is 0 on every cycle not immediately following a wrap step.
REQ-020 load has priority over a simultaneous tick; that tick is consumed and produces no step.
REQ-021 load is accepted when both nibbles are <=9 and value < MOD: bcd <= load_val at that edge, tc stays 0.
REQ-022 A load that fails REQ-021 leaves bcd unchanged and pulses load_err for one cycle.
REQ-023 load held high for several cycles reloads on each cycle; each rejected cycle pulses load_err.
REQ-024 A direction change between ticks takes effect at the next step; no glitch on bcd.
REQ-025 en=0 discards ticks; they are not queued.
REQ-026 bcd never holds a non-BCD nibble or a value >= MOD.
REQ-027 With MOD <= 10, tens stays 0 permanently.

Reset
REQ-028 rst asynchronously forces: bcd=8'h00, tc=0, load_err=0.
REQ-029 rst sets all synchronizer and history flops to 1, matching the upstream divider's high reset level, so no tick is produced when reset is released while slow_clk=1.
REQ-030 rst mid-count discards pending sync state; the first tick after release requires a genuine slow_clk 0 -> 1 transition.

Verification
REQ-031 Reset release with slow_clk=1, en=1, up=1, then hold slow_clk high for 10 cycles -> no tick, bcd=8'h00.
REQ-032 MOD=60, up=1, en=1, 60 slow_clk periods from reset -> bcd steps 00..59 then 00; exactly one tc pulse, aligned with the 59 -> 00 step.
REQ-033 up=0 from bcd=8'h00, one slow_clk rise -> bcd=8'h59 and tc=1; next rise -> bcd=8'h58 and tc=0; 8'h10 decrements to 8'h09.
REQ-034 load=1 with load_val=8'h42 in the same cycle as tick -> bcd=8'h42 with no step; load_val=8'h3A or 8'h60 -> bcd unchanged and load_err=1 for one cycle.
REQ-035 en=0 across 3 slow_clk rises, then en=1 -> bcd unchanged until the next rise, then +1; tick still pulses during en=0.
REQ-036 rst asserted mid-cycle at bcd=8'h27 -> bcd=8'h00 immediately, without waiting for an I_CLK edge; tick=0 and tc=0 until a fresh slow_clk rise.
